row_accum_ctrl: RTL and testbench

//  Parametrised row-accumulation controller for the sparse MAC datapath.

---
 rtl/row_accum_ctrl_if.sv | 30 +++
 rtl/row_accum_ctrl.sv | 124 ++++++++++++
 tb/tb_row_accum_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/row_accum_ctrl_if.sv
// Accumulator-side and output-side signals of the row accumulation controller.
// The datapath/driver side is master; the controller is slave.
interface row_accum_ctrl_if #(
    parameter int DW    = 24,
    parameter int SLOTS = 4,
    parameter int CW    = 4
);
    logic                  row_start;
    logic                  elem_valid;
    logic [DW:0]           accum_in;
    logic                  accum_valid;
    logic                  accum_ready;
    logic [DW-1:0]         feedback;
    logic [CW-1:0]         lat_count;
    logic [SLOTS*DW-1:0]   out_sum;
    logic [CW-1:0]         out_cnt;
    logic                  out_overflow;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output row_start, elem_valid, accum_in, accum_valid, out_ready,
        input  accum_ready, feedback, lat_count, out_sum, out_cnt, out_overflow, out_valid
    );

    modport slave (
        input  row_start, elem_valid, accum_in, accum_valid, out_ready,
        output accum_ready, feedback, lat_count, out_sum, out_cnt, out_overflow, out_valid
    );
endinterface

// File: rtl/row_accum_ctrl.sv
// Row accumulation controller: adder feedback gating after pipeline fill, and
// collection of per-row partial sums flushed as one packed word on the row marker.
module row_accum_ctrl #(
    parameter int DW      = 24,
    parameter int SLOTS   = 4,
    parameter int ADD_LAT = 5,
    parameter int CW      = 4
) (
    input  logic            clock,
    input  logic            reset,
    row_accum_ctrl_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           wr_ptr, wr_ptr_n;
    logic [CW-1:0]           lat_count;
    logic                    fb_active;
    logic                    row_ovf, row_ovf_n;
    logic [SLOTS-1:0][DW-1:0] slots, slots_n, slots_wr;
    logic [SLOTS-1:0][DW-1:0] out_sum, out_sum_n;
    logic [CW-1:0]           out_cnt, out_cnt_n;
    logic                    out_overflow, out_overflow_n;
    logic                    out_valid, out_valid_n;

    logic          accum_ready, take, marker, room, lat_full;
    logic [DW-1:0] data;

    assign accum_ready = !out_valid || bus.out_ready;
    assign take        = bus.accum_valid && accum_ready;
    assign marker      = bus.accum_in[DW];
    assign data        = bus.accum_in[DW-1:0];
    assign room        = (state != FULL);
    assign lat_full    = (lat_count == CW'(ADD_LAT));

    // Latency path: independent of the collector.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_count <= '0;
            fb_active <= 1'b0;
        end else begin
            if (bus.row_start)
                lat_count <= CW'(1);
            else if (bus.elem_valid && lat_count < CW'(ADD_LAT))
                lat_count <= lat_count + CW'(1);

            if (bus.row_start)
                fb_active <= 1'b0;
            else if (lat_full)
                fb_active <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= EMPTY;
            wr_ptr       <= '0;
            slots        <= '0;
            row_ovf      <= 1'b0;
            out_sum      <= '0;
            out_cnt      <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            slots        <= slots_n;
            row_ovf      <= row_ovf_n;
            out_sum      <= out_sum_n;
            out_cnt      <= out_cnt_n;
            out_overflow <= out_overflow_n;
            out_valid    <= out_valid_n;
        end
    end

    always_comb begin
        wr_ptr_n       = wr_ptr;
        slots_n        = slots;
        row_ovf_n      = row_ovf;
        out_sum_n      = out_sum;
        out_cnt_n      = out_cnt;
        out_overflow_n = out_overflow;
        out_valid_n    = out_valid && !bus.out_ready;

        // Slot image with this beat written in, used both for fill and flush.
        slots_wr = slots;
        for (int k = 0; k < SLOTS; k++)
            if (room && wr_ptr == CW'(k))
                slots_wr[k] = data;

        if (take) begin
            if (marker) begin
                out_sum_n      = slots_wr;
                out_cnt_n      = wr_ptr + CW'(room);
                out_overflow_n = row_ovf | !room;
                out_valid_n    = 1'b1;
                slots_n        = '0;
                wr_ptr_n       = '0;
                row_ovf_n      = 1'b0;
            end else begin
                slots_n = slots_wr;
                if (room)
                    wr_ptr_n = wr_ptr + CW'(1);
                else
                    row_ovf_n = 1'b1;
            end
        end

        if (wr_ptr_n == '0)
            state_n = EMPTY;
        else if (wr_ptr_n == CW'(SLOTS))
            state_n = FULL;
        else
            state_n = FILL;
    end

    assign bus.accum_ready  = accum_ready;
    assign bus.feedback     = (!bus.row_start && (fb_active || lat_full)) ? data : '0;
    assign bus.lat_count    = lat_count;
    assign bus.out_sum      = out_sum;
    assign bus.out_cnt      = out_cnt;
    assign bus.out_overflow = out_overflow;
    assign bus.out_valid    = out_valid;
endmodule

// File: tb/tb_row_accum_ctrl.sv
// Randomized scoreboard bench for row_accum_ctrl against a queue-based row model.
module tb_row_accum_ctrl;
    localparam int DW = 24, SLOTS = 4, ADD_LAT = 5, CW = 4;

    typedef struct {
        logic [SLOTS*DW-1:0] sum;
        logic [CW-1:0]       cnt;
        logic                ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    row_accum_ctrl_if #(.DW(DW), .SLOTS(SLOTS), .CW(CW)) bus ();

    row_accum_ctrl #(.DW(DW), .SLOTS(SLOTS), .ADD_LAT(ADD_LAT), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit started = 0;

    // Reference model state
    exp_t          exp_q[$];
    logic [DW-1:0] part[$];
    bit            m_ovf = 0;
    bit            m_valid = 0;
    int            m_lat = 0;
    bit            m_fb = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ready, take;
        exp_t e;
        logic [DW-1:0] d;
        if (reset) begin
            exp_q.delete(); part.delete();
            m_ovf = 0; m_valid = 0; m_lat = 0; m_fb = 0;
            return;
        end
        ready = !m_valid || bus.out_ready;
        if (bus.row_start) m_fb = 0;
        else if (m_lat == ADD_LAT) m_fb = 1;
        if (bus.row_start) m_lat = 1;
        else if (bus.elem_valid && m_lat < ADD_LAT) m_lat++;
        take = bus.accum_valid && ready;
        d = bus.accum_in[DW-1:0];
        if (take) begin
            if (part.size() < SLOTS) part.push_back(d);
            else m_ovf = 1;
        end
        if (take && bus.accum_in[DW]) begin
            e.sum = '0;
            foreach (part[k]) e.sum[k*DW +: DW] = part[k];
            e.cnt = CW'(part.size());
            e.ovf = m_ovf;
            exp_q.push_back(e);
            part.delete();
            m_ovf = 0;
            m_valid = 1;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic rs, input logic ev, input logic av, input logic ordy,
                        input logic [DW:0] din);
        bus.row_start   = rs;
        bus.elem_valid  = ev;
        bus.accum_valid = av;
        bus.out_ready   = ordy;
        bus.accum_in    = din;
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic beat(input logic mk, input logic [DW-1:0] d, input logic ordy);
        step(1'b0, 1'b0, 1'b1, ordy, {mk, d});
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, ordy, '0);
    endtask

    // Monitor: checks comb/latency outputs each cycle and the scoreboard head when a word is presented.
    exp_t mon_e;
    logic [DW-1:0] mon_fb;
    always @(negedge clock) begin
        if (started && !reset) begin
            chk("accum_ready", bus.accum_ready, !m_valid || bus.out_ready);
            chk("out_valid", bus.out_valid, m_valid);
            chk("lat_count", bus.lat_count, CW'(m_lat));
            mon_fb = (!bus.row_start && (m_fb || m_lat == ADD_LAT)) ? bus.accum_in[DW-1:0] : '0;
            chk("feedback", bus.feedback, mon_fb);
            if (bus.out_valid && m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL scoreboard_empty: got out_valid=1 expected no word");
                end else begin
                    mon_e = exp_q[0];
                    chk("out_sum", bus.out_sum, mon_e.sum);
                    chk("out_cnt", bus.out_cnt, mon_e.cnt);
                    chk("out_overflow", bus.out_overflow, mon_e.ovf);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] r;
        bus.row_start = 0; bus.elem_valid = 0; bus.accum_valid = 0;
        bus.out_ready = 1; bus.accum_in = '0;
        reset = 1;
        idle(1); idle(1);
        reset = 0;
        started = 1;
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_cnt", bus.out_cnt, 0);
        chk("rst_out_ovf", bus.out_overflow, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_lat_count", bus.lat_count, 0);

        // Latency fill and feedback gating
        step(1, 1, 0, 1, {1'b0, 24'h0000AA});
        for (int i = 0; i < 6; i++) begin
            r = DW'($urandom());
            step(0, 1, 0, 1, {1'b0, r});
        end
        chk("lat_sat", bus.lat_count, ADD_LAT);
        step(1, 0, 0, 1, {1'b0, 24'h123456});
        chk("fb_row_start", bus.feedback, 0);

        // Three-entry row
        beat(0, 24'h000011, 1); beat(0, 24'h000022, 1); beat(1, 24'h000033, 1);
        chk("t2_cnt", bus.out_cnt, 3);
        chk("t2_sum", bus.out_sum, {24'h0, 24'h33, 24'h22, 24'h11});
        idle(1);

        // Overflow row
        for (int i = 1; i <= 5; i++) beat(0, DW'(i), 1);
        beat(1, 24'd6, 1);
        chk("t3_cnt", bus.out_cnt, 4);
        chk("t3_ovf", bus.out_overflow, 1);
        chk("t3_sum", bus.out_sum, {24'd4, 24'd3, 24'd2, 24'd1});

        // Backpressure: word held for 3 cycles while beats stall
        beat(0, 24'h000001, 0);
        for (int i = 0; i < 3; i++) begin
            beat(0, 24'h0000EE, 0);
            chk("t4_stall_ready", bus.accum_ready, 0);
        end
        beat(1, 24'h000007, 1);
        chk("t4_valid_held", bus.out_valid, 1);
        chk("t4_slot0", bus.out_sum[DW-1:0], 24'h7);
        idle(1);

        // Reset mid-row and during a pending word
        beat(1, 24'h000005, 0);
        beat(0, 24'h000001, 0); beat(0, 24'h000002, 0);
        reset = 1;
        idle(0);
        reset = 0;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_sum", bus.out_sum, 0);
        chk("t5_cnt", bus.out_cnt, 0);
        beat(1, 24'h000009, 1);
        chk("t5_cnt1", bus.out_cnt, 1);
        chk("t5_slot0", bus.out_sum, 24'h9);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) reset = 1;
            r = DW'($urandom());
            if ($urandom_range(0, 7) == 0) r = '0;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 {$urandom_range(0, 5) == 0, r});
            reset = 0;
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
